// File: rtl/arbiter_types.sv
// Shared types for the L1-to-memory line-port arbiter: FSM states, owner and command encodings.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } arb_cmd_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory line port between the I-cache and the D-cache.
// One owner at a time; the pmem command is latched at grant and held until pmem_resp.
//
// Handshake: a requester holds i_read / d_read / d_write high until its one-cycle
// *_resp pulse, then drops it in the following cycle. pmem_read/pmem_write stay high
// until the cycle in which pmem_resp is sampled; pmem_rdata is valid with pmem_resp.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        dbg_state
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, last_owner_q, grant_owner;
  arb_cmd_t   cmd_q, grant_cmd;
  logic       grant;
  logic       serve_done;
  logic       i_req, d_req;

  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = OWN_I;
    grant_cmd   = CMD_READ;
    serve_done  = 1'b0;
    i_req       = i_read;
    d_req       = d_read | d_write;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant = 1'b1;
          if (i_req && d_req)
            grant_owner = (RR_EN && last_owner_q == OWN_D) ? OWN_I : OWN_D;
          else
            grant_owner = d_req ? OWN_D : OWN_I;
          // A write-back wins over a simultaneous read from the same port.
          grant_cmd = (grant_owner == OWN_D && d_write) ? CMD_WRITE : CMD_READ;
          state_d   = (grant_owner == OWN_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          serve_done = 1'b1;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      cmd_q        <= CMD_READ;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (grant) begin
        owner_q      <= grant_owner;
        last_owner_q <= grant_owner;
        cmd_q        <= grant_cmd;
        pmem_addr    <= (grant_owner == OWN_D) ? d_addr : i_addr;
        pmem_wdata   <= (grant_owner == OWN_D) ? d_wdata : '0;
        pmem_read    <= (grant_cmd == CMD_READ);
        pmem_write   <= (grant_cmd == CMD_WRITE);
      end
      if (serve_done) begin
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
        if (cmd_q == CMD_READ) begin
          if (owner_q == OWN_D) d_rdata <= pmem_rdata;
          else                  i_rdata <= pmem_rdata;
        end
        // The resp pulse lines up with the single RESP cycle.
        i_resp <= (owner_q == OWN_I);
        d_resp <= (owner_q == OWN_D);
      end
    end
  end

`ifndef SYNTHESIS
  a_hold_cmd: assert property (@(posedge clk) disable iff (!rst)
    ((state_q == SERVE_I || state_q == SERVE_D) && !pmem_resp)
      |=> ($stable(pmem_addr) && $stable(pmem_wdata)));

  a_one_resp: assert property (@(posedge clk) disable iff (!rst) !(i_resp && d_resp));

  a_rw_excl: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> !(d_read && d_write))
    else $warning("cache_arbiter: d_read and d_write both high, serviced as a write");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: one round-robin instance and one D-priority instance
// driven by the same stimulus and a small memory responder.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [ADDR_W-1:0] I_ADDR = 32'h0000_0200;
  localparam logic [ADDR_W-1:0] D_ADDR = 32'h4000_0080;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;

  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [1:0]        dbg_state;

  logic [LINE_W-1:0] f_i_rdata, f_d_rdata, f_pmem_wdata;
  logic              f_i_resp, f_d_resp, f_pmem_read, f_pmem_write;
  logic [ADDR_W-1:0] f_pmem_addr;
  logic [1:0]        f_dbg_state;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state)
  );

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(f_d_rdata), .d_resp(f_d_resp),
    .pmem_read(f_pmem_read), .pmem_write(f_pmem_write), .pmem_addr(f_pmem_addr),
    .pmem_wdata(f_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(f_dbg_state)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for a command, checks it is held, answers after lat cycles and returns in RESP.
  // mode 1: scramble D inputs after grant; mode 2: drop i_read after grant.
  task automatic run_txn(input int lat, input logic [LINE_W-1:0] rdata,
                         input logic [ADDR_W-1:0] exp_addr, input logic exp_wr,
                         input logic chk_wdata, input logic [LINE_W-1:0] exp_wdata,
                         input int mode, output logic owner_d, output int wait_cyc);
    int n = 0;
    @(negedge clk);
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    wait_cyc = n;
    check_eq("grant_seen", n < 20, 1'b1);
    owner_d = (dbg_state == ST_SERVE_D);
    check_eq("cmd_read", pmem_read, !exp_wr);
    check_eq("cmd_write", pmem_write, exp_wr);
    check_eq("cmd_addr", pmem_addr, exp_addr);
    if (chk_wdata) check_eq("cmd_wdata", pmem_wdata, exp_wdata);
    if (mode == 1) begin
      d_addr  = ~d_addr;
      d_wdata = ~d_wdata;
    end else if (mode == 2) begin
      i_read = 1'b0;
    end
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check_eq("hold_addr", pmem_addr, exp_addr);
      check_eq("hold_cmd", {pmem_read, pmem_write}, {!exp_wr, exp_wr});
      if (chk_wdata) check_eq("hold_wdata", pmem_wdata, exp_wdata);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    check_eq("cmd_clear", {pmem_read, pmem_write}, 2'b00);
    check_eq("resp_state", dbg_state, ST_RESP);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic              own;
    logic              exp_own;
    int                wc;
    logic [LINE_W-1:0] data_k;
    logic [LINE_W-1:0] exp_d_rdata;
    logic [LINE_W-1:0] exp_i_rdata;
    logic [LINE_W-1:0] wb_data;

    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;

    // reset values
    repeat (2) @(negedge clk);
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_pmem_cmd", {pmem_read, pmem_write}, 2'b00);
    check_eq("rst_pmem_addr", pmem_addr, '0);
    check_eq("rst_pmem_wdata", pmem_wdata, '0);
    check_eq("rst_rdata", {i_rdata, d_rdata}, '0);
    check_eq("rst_resp", {i_resp, d_resp}, 2'b00);
    rst = 1'b1;
    @(negedge clk);

    // single I read, memory answers 4 cycles after the command
    exp_i_rdata = {8{32'hC0DE_0100}};
    i_addr = 32'h0000_0100;
    i_read = 1'b1;
    run_txn(4, exp_i_rdata, 32'h0000_0100, 1'b0, 1'b0, '0, 0, own, wc);
    check_eq("i_grant_latency", wc, 0);
    check_eq("i_owner", own, 1'b0);
    check_eq("i_resp_pulse", i_resp, 1'b1);
    check_eq("i_other_resp", d_resp, 1'b0);
    check_eq("i_rdata", i_rdata, exp_i_rdata);
    i_read = 1'b0;
    @(negedge clk);
    check_eq("i_resp_one_cycle", i_resp, 1'b0);
    check_eq("i_back_idle", dbg_state, ST_IDLE);
    check_eq("i_rdata_hold", i_rdata, exp_i_rdata);

    // simultaneous requests after reset: RR alternates starting with D, fixed priority always D
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_d_rdata = '0;
    exp_i_rdata = '0;
    i_addr = I_ADDR;
    d_addr = D_ADDR;
    i_read = 1'b1;
    d_read = 1'b1;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_own = exp_q.pop_front();
      data_k  = {8{32'h1000_0000 + k}};
      run_txn(2, data_k, exp_own ? D_ADDR : I_ADDR, 1'b0, 1'b0, '0, 0, own, wc);
      check_eq("rr_owner", own, exp_own);
      check_eq("rr_resp", {i_resp, d_resp}, exp_own ? 2'b01 : 2'b10);
      if (exp_own) exp_d_rdata = data_k;
      else         exp_i_rdata = data_k;
      check_eq("rr_d_rdata", d_rdata, exp_d_rdata);
      check_eq("rr_i_rdata", i_rdata, exp_i_rdata);
      check_eq("fp_addr", f_pmem_addr, D_ADDR);
      check_eq("fp_resp", {f_i_resp, f_d_resp}, 2'b01);
      check_eq("fp_d_rdata", f_d_rdata, data_k);
    end
    check_eq("fp_i_never", f_i_rdata, '0);
    i_read = 1'b0;
    d_read = 1'b0;
    @(negedge clk);

    // write-back, D inputs change mid-service and must not reach pmem
    wb_data = {32{8'hA5}};
    d_addr  = 32'h8000_0040;
    d_wdata = wb_data;
    d_write = 1'b1;
    run_txn(3, {8{32'hDEAD_BEEF}}, 32'h8000_0040, 1'b1, 1'b1, wb_data, 1, own, wc);
    check_eq("wb_owner", own, 1'b1);
    check_eq("wb_resp", {i_resp, d_resp}, 2'b01);
    check_eq("wb_d_rdata_kept", d_rdata, exp_d_rdata);
    d_write = 1'b0;
    @(negedge clk);
    check_eq("wb_resp_one_cycle", d_resp, 1'b0);

    // I-cache drops its request mid-service
    exp_i_rdata = {8{32'h3333_0300}};
    i_addr = 32'h0000_0300;
    i_read = 1'b1;
    run_txn(3, exp_i_rdata, 32'h0000_0300, 1'b0, 1'b0, '0, 2, own, wc);
    check_eq("drop_i_resp", i_resp, 1'b1);
    check_eq("drop_i_rdata", i_rdata, exp_i_rdata);
    @(negedge clk);
    @(negedge clk);
    check_eq("drop_no_regrant", {pmem_read, pmem_write}, 2'b00);
    check_eq("drop_idle", dbg_state, ST_IDLE);

    // spurious pmem_resp while idle
    pmem_rdata = {8{32'hBAD0_BAD0}};
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    check_eq("spur_state", dbg_state, ST_IDLE);
    @(negedge clk);
    check_eq("spur_resp", {i_resp, d_resp}, 2'b00);
    check_eq("spur_i_rdata", i_rdata, exp_i_rdata);
    check_eq("spur_d_rdata", d_rdata, exp_d_rdata);

    // d_read and d_write together: serviced as a write
    wb_data = {8{32'h1234_5678}};
    d_addr  = 32'h8000_0080;
    d_wdata = wb_data;
    d_read  = 1'b1;
    d_write = 1'b1;
    run_txn(2, {8{32'hF00D_F00D}}, 32'h8000_0080, 1'b1, 1'b1, wb_data, 0, own, wc);
    check_eq("rw_resp", {i_resp, d_resp}, 2'b01);
    check_eq("rw_d_rdata_kept", d_rdata, exp_d_rdata);
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of a write-back
    d_addr  = 32'h8000_00C0;
    d_write = 1'b1;
    @(negedge clk);
    check_eq("mid_write_on", pmem_write, 1'b1);
    check_eq("mid_serve_d", dbg_state, ST_SERVE_D);
    #2 rst = 1'b0;
    #1;
    check_eq("async_write_off", pmem_write, 1'b0);
    check_eq("async_state", dbg_state, ST_IDLE);
    check_eq("async_addr", pmem_addr, '0);
    d_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_no_resp", {i_resp, d_resp}, 2'b00);
      check_eq("post_rst_idle", dbg_state, ST_IDLE);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache (fetch-stage misses, read-only) and the D-cache (memory-stage misses and write-backs).
- Grants one requester at a time and holds the latched command on pmem until pmem_resp.
- Returns read data to the owner through a registered one-cycle response.
- Sits between the two L1 caches and the memory model or L2, below the pipeline stages that stall on IF_stall and MA_stall.

Parameters:
ADDR_W, 32, byte address width of all request ports
LINE_W, 256, cache line width in bits
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = D-cache always wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (arbiter held in reset while rst == 0)
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  registered line data to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write-back request
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_rdata  out  LINE_W  registered line data to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_addr  out  ADDR_W  latched address
pmem_wdata  out  LINE_W  latched write line
pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion pulse

Behaviour:
- Reset: asynchronous, active-low; takes effect immediately, independent of clk.
  - State goes to IDLE; last_owner = I.
  - All outputs 0: pmem_read, pmem_write, pmem_addr, pmem_wdata, i_rdata, d_rdata, i_resp, d_resp.
- State machine: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE:
  - Request sample: i_req = i_read; d_req = d_read | d_write.
  - Only one requester asserting: grant it.
  - Both asserting with RR_EN = 1: grant the requester not equal to last_owner. With RR_EN = 0: grant D.
  - On grant, at the same edge: latch owner, addr, wdata and cmd into pmem_* registers; update last_owner.
  - pmem_read or pmem_write goes high the cycle after the request is first seen, so grant latency is 1 cycle.
- SERVE_x:
  - Hold pmem_* stable; ignore every requester input, including a requester that drops its request mid-service.
  - On pmem_resp: clear pmem_read and pmem_write; if the command was a read, capture pmem_rdata into the owner's rdata register; go to RESP.
- RESP:
  - Assert the owner's resp for exactly one cycle; the other resp stays 0.
  - i_rdata and d_rdata hold their value until overwritten by that port's next read.
  - Return to IDLE. Requests are not sampled in RESP, so a requester must drop its request in the cycle after its resp.
- d_read and d_write both high: treated as a write (protocol violation; flagged by a simulation-only assertion).
- pmem_resp arriving in IDLE or RESP: ignored.
- Throughput: minimum of 3 cycles per transaction plus memory latency (grant, ≥1 serve, resp).
- No combinational path from any request input to any pmem_* output; all outputs are registered.
- Reset mid-transaction: the in-flight transaction is dropped, no resp is issued, and the requester re-arbitrates after reset.

Decomposition:
- Shared package arbiter_types:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, RESP}
  - arb_owner_t enum {OWN_I, OWN_D}
  - arb_cmd_t enum {CMD_READ, CMD_WRITE}
- No sub-module: the grant-pick logic is about 10 lines and stays inline.

Test Plan:
- Reset: hold rst = 0 mid-SERVE_D with pmem_write = 1, then release → pmem_write = 0 immediately (asynchronously); state IDLE; no d_resp pulse.
- Single I read: i_read = 1, i_addr = 0x0000_0100; memory responds 4 cycles after the command → pmem_read high from cycle 1, pmem_addr = 0x100; i_rdata = pmem_rdata and i_resp = 1 for exactly one cycle, one cycle after pmem_resp.
- Simultaneous, RR_EN = 1, after reset: i_read and d_read both held → D granted first (last_owner = I); I granted next; then D and I alternate while both stay asserted.
- Simultaneous, RR_EN = 0: both held for 3 transactions → all 3 grants go to D; I is never granted.
- Write-back: d_write = 1, d_addr = 0x8000_0040, d_wdata = 256'hA5… → pmem_write = 1 with that addr and data held unchanged until pmem_resp; d_resp pulses once; d_rdata unchanged.
- Robustness:
  - i_read drops mid-SERVE_I → transaction still completes and i_resp pulses.
  - Spurious pmem_resp in IDLE → no resp output.
  - d_read and d_write both high → write performed.
